// File: rtl/snn_pkg.sv
// Shared types and widths for the spiking-neuron layer sequencer.
package snn_pkg;

   localparam int V_MEM_W  = 9;
   localparam int WEIGHT_W = 8;
   localparam int CFG_W    = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_V,
      ACC,
      FIRE,
      DONE
   } seq_state_t;

endpackage

// File: rtl/snn_sat_clamp.sv
// Saturating fix-up for one membrane accumulation step: when the neuron adder
// overflows (operands share a sign that the sum does not), the result is
// pinned to the most positive or most negative membrane value.
module snn_sat_clamp
   import snn_pkg::*;
(
   input  logic signed [V_MEM_W-1:0]  acc,
   input  logic signed [WEIGHT_W-1:0] weight,
   input  logic signed [V_MEM_W-1:0]  sum,
   output logic signed [V_MEM_W-1:0]  result
);

   localparam logic signed [V_MEM_W-1:0] V_MAX = {1'b0, {(V_MEM_W-1){1'b1}}};
   localparam logic signed [V_MEM_W-1:0] V_MIN = {1'b1, {(V_MEM_W-1){1'b0}}};

   function automatic logic signed [V_MEM_W-1:0] sat_fix(
      input logic signed [V_MEM_W-1:0]  a,
      input logic signed [WEIGHT_W-1:0] b,
      input logic signed [V_MEM_W-1:0]  s
   );
      if ((a[V_MEM_W-1] == b[WEIGHT_W-1]) && (s[V_MEM_W-1] != a[V_MEM_W-1]))
         return a[V_MEM_W-1] ? V_MIN : V_MAX;
      return s;
   endfunction

   // Clamp the wrapped sum back into range on overflow
   always_comb begin
      result = sat_fix(acc, weight, sum);
   end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Timestep sequencer for one SNN layer. For each neuron j it reads the stored
// membrane potential, accumulates the weights of every active input spike
// through the external neuron datapath, then fires/leaks and writes the
// membrane back. Optional feature macro: SNN_SAT_EN (saturating accumulation
// instead of two's-complement wrap).
module snn_layer_sequencer
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS = 16,
   parameter int NUM_INPUTS  = 16,
   localparam int JW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int AW = $clog2(NUM_NEURONS * NUM_INPUTS),
   localparam int KW = $clog2(NUM_INPUTS + 1)
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic                       start,
   input  logic [NUM_INPUTS-1:0]      in_spikes,
   input  logic [CFG_W-1:0]           cfg_beta,
   input  logic [CFG_W-1:0]           cfg_v_th,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_NEURONS-1:0]     out_spikes,
   output logic                       w_rd_en,
   output logic [AW-1:0]              w_addr,
   input  logic signed [WEIGHT_W-1:0] w_rdata,
   output logic                       vmem_rd_en,
   output logic                       vmem_we,
   output logic [JW-1:0]              vmem_addr,
   output logic signed [V_MEM_W-1:0]  vmem_wdata,
   input  logic signed [V_MEM_W-1:0]  vmem_rdata,
   output logic signed [WEIGHT_W-1:0] nrn_weight,
   output logic signed [V_MEM_W-1:0]  nrn_v_mem_in,
   output logic [CFG_W-1:0]           nrn_beta,
   output logic                       nrn_function_sel,
   output logic [CFG_W-1:0]           nrn_v_th,
   input  logic                       nrn_spike,
   input  logic signed [V_MEM_W-1:0]  nrn_v_mem_out
);

   localparam logic [KW-1:0] K_LAST = KW'(NUM_INPUTS);
   localparam logic [JW-1:0] J_LAST = JW'(NUM_NEURONS - 1);

   seq_state_t                 state;
   logic [JW-1:0]              j;
   logic [KW-1:0]              k;
   logic [KW-1:0]              k_nxt;
   logic signed [V_MEM_W-1:0]  acc;
   logic signed [V_MEM_W-1:0]  acc_upd;
   logic [NUM_INPUTS-1:0]      spikes_lat;
   logic [NUM_INPUTS:0]        spike_ext;
   logic [CFG_W-1:0]           beta_lat;
   logic [CFG_W-1:0]           v_th_lat;
   // Spike bit of the input whose weight is arriving this cycle (k-1)
   logic                       w_pend;

   function automatic logic [AW-1:0] weight_addr(input logic [JW-1:0] jj,
                                                 input logic [KW-1:0] kk);
      return AW'(jj) * AW'(NUM_INPUTS) + AW'(kk);
   endfunction

   assign k_nxt     = k + 1'b1;
   // Extra zero bit makes the k=NUM_INPUTS slot a natural "no read" entry
   assign spike_ext = {1'b0, spikes_lat};

`ifdef SNN_SAT_EN
   snn_sat_clamp u_sat_clamp (
      .acc    (acc),
      .weight (w_rdata),
      .sum    (nrn_v_mem_out),
      .result (acc_upd)
   );
`else
   assign acc_upd = nrn_v_mem_out;
`endif

   // Sequencer FSM; RAM strobes and status are registered one state ahead
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         j          <= '0;
         k          <= '0;
         acc        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         out_spikes <= '0;
         spikes_lat <= '0;
         beta_lat   <= '0;
         v_th_lat   <= '0;
         w_pend     <= 1'b0;
         w_rd_en    <= 1'b0;
         w_addr     <= '0;
         vmem_rd_en <= 1'b0;
         vmem_we    <= 1'b0;
         vmem_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  spikes_lat <= in_spikes;
                  beta_lat   <= cfg_beta;
                  v_th_lat   <= cfg_v_th;
                  out_spikes <= '0;
                  j          <= '0;
                  busy       <= 1'b1;
                  vmem_rd_en <= 1'b1;
                  vmem_addr  <= '0;
                  state      <= RD_V;
               end
            end
            RD_V: begin
               vmem_rd_en <= 1'b0;
               k          <= '0;
               w_pend     <= 1'b0;
               w_rd_en    <= spikes_lat[0];
               w_addr     <= weight_addr(j, '0);
               state      <= ACC;
            end
            ACC: begin
               if (k == '0)
                  acc <= vmem_rdata;
               else if (w_pend)
                  acc <= acc_upd;
               w_pend <= w_rd_en;
               if (k == K_LAST) begin
                  w_rd_en   <= 1'b0;
                  vmem_we   <= 1'b1;
                  vmem_addr <= j;
                  state     <= FIRE;
               end else begin
                  k       <= k_nxt;
                  w_rd_en <= spike_ext[k_nxt];
                  w_addr  <= weight_addr(j, k_nxt);
               end
            end
            FIRE: begin
               vmem_we       <= 1'b0;
               out_spikes[j] <= nrn_spike;
               if (j == J_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  j          <= j + 1'b1;
                  vmem_rd_en <= 1'b1;
                  vmem_addr  <= j + 1'b1;
                  state      <= RD_V;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Neuron datapath operand steering: add mode in ACC, fire mode in FIRE
   always_comb begin
      nrn_weight       = '0;
      nrn_function_sel = 1'b0;
      nrn_v_mem_in     = acc;
      if ((state == ACC) && (k != '0))
         nrn_weight = w_rdata;
      if (state == FIRE)
         nrn_function_sel = 1'b1;
   end

   assign nrn_beta   = beta_lat;
   assign nrn_v_th   = v_th_lat;
   assign vmem_wdata = nrn_v_mem_out;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed bench for snn_layer_sequencer with 2 neurons x 4 inputs, behavioural
// weight/membrane RAMs and a simple integrate-and-fire neuron model.
module tb_snn_layer_sequencer;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [3:0]        in_spikes;
   logic [7:0]        cfg_beta;
   logic [7:0]        cfg_v_th;
   logic              busy;
   logic              done;
   logic [1:0]        out_spikes;
   logic              w_rd_en;
   logic [2:0]        w_addr;
   logic signed [7:0] w_rdata;
   logic              vmem_rd_en;
   logic              vmem_we;
   logic [0:0]        vmem_addr;
   logic signed [8:0] vmem_wdata;
   logic signed [8:0] vmem_rdata;
   logic signed [7:0] nrn_weight;
   logic signed [8:0] nrn_v_mem_in;
   logic [7:0]        nrn_beta;
   logic              nrn_function_sel;
   logic [7:0]        nrn_v_th;
   logic              nrn_spike;
   logic signed [8:0] nrn_v_mem_out;

   // RAM models and preload port
   logic signed [7:0] wmem [0:7];
   logic signed [8:0] vram [0:1];
   logic              ld_en = 1'b0;
   logic signed [8:0] ld_v0, ld_v1;
   logic signed [7:0] ld_w;
   logic              reset_on_spike;

   logic [0:0]        wr_addr_q [$];
   logic signed [8:0] wr_data_q [$];
   logic [2:0]        rd_addr_q [$];

   int checks = 0;
   int errors = 0;
   int lat;

   always #5 clk = ~clk;

   snn_layer_sequencer #(.NUM_NEURONS(2), .NUM_INPUTS(4)) dut (
      .wb_clk_i         (clk),
      .wb_rst_i         (rst),
      .start            (start),
      .in_spikes        (in_spikes),
      .cfg_beta         (cfg_beta),
      .cfg_v_th         (cfg_v_th),
      .busy             (busy),
      .done             (done),
      .out_spikes       (out_spikes),
      .w_rd_en          (w_rd_en),
      .w_addr           (w_addr),
      .w_rdata          (w_rdata),
      .vmem_rd_en       (vmem_rd_en),
      .vmem_we          (vmem_we),
      .vmem_addr        (vmem_addr),
      .vmem_wdata       (vmem_wdata),
      .vmem_rdata       (vmem_rdata),
      .nrn_weight       (nrn_weight),
      .nrn_v_mem_in     (nrn_v_mem_in),
      .nrn_beta         (nrn_beta),
      .nrn_function_sel (nrn_function_sel),
      .nrn_v_th         (nrn_v_th),
      .nrn_spike        (nrn_spike),
      .nrn_v_mem_out    (nrn_v_mem_out)
   );

   // Synchronous RAMs with one-cycle read latency
   always @(posedge clk) begin
      if (ld_en) begin
         vram[0] <= ld_v0;
         vram[1] <= ld_v1;
         for (int i = 0; i < 8; i++) wmem[i] <= ld_w;
      end else if (vmem_we) begin
         vram[vmem_addr] <= vmem_wdata;
      end
      if (w_rd_en)    w_rdata    <= wmem[w_addr];
      if (vmem_rd_en) vmem_rdata <= vram[vmem_addr];
   end

   // Integrate-and-fire neuron: add weight, or compare against threshold
   always_comb begin
      nrn_spike     = 1'b0;
      nrn_v_mem_out = nrn_v_mem_in + nrn_weight;
      if (nrn_function_sel) begin
         nrn_spike     = (nrn_v_mem_in >= $signed({1'b0, nrn_v_th}));
         nrn_v_mem_out = (nrn_spike && reset_on_spike) ? 9'sd0 : nrn_v_mem_in;
      end
   end

   // Transaction monitor
   always @(negedge clk) begin
      if (vmem_we) begin
         wr_addr_q.push_back(vmem_addr);
         wr_data_q.push_back(vmem_wdata);
      end
      if (w_rd_en) rd_addr_q.push_back(w_addr);
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_rams(input logic signed [8:0] v0, input logic signed [8:0] v1,
                            input logic signed [7:0] w);
      @(negedge clk);
      ld_v0 = v0; ld_v1 = v1; ld_w = w; ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic begin_ts(input logic [3:0] s, input logic [7:0] b, input logic [7:0] v);
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      @(negedge clk);
      in_spikes = s; cfg_beta = b; cfg_v_th = v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_spikes = ~s; cfg_beta = ~b; cfg_v_th = ~v;
   endtask

   // Counts edges from the accept edge (lat=1) until done is seen
   task automatic wait_done(input int poke_at, output int n);
      n = 1;
      while (done !== 1'b1 && n < 60) begin
         start = (n == poke_at);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
   endtask

   task automatic check_writes(input string tag, input logic signed [8:0] e0,
                               input logic signed [8:0] e1);
      chk({tag, "_nwr"}, wr_data_q.size(), 2);
      if (wr_data_q.size() == 2) begin
         chk({tag, "_wa0"}, wr_addr_q[0], 0);
         chk({tag, "_wd0"}, wr_data_q[0], e0);
         chk({tag, "_wa1"}, wr_addr_q[1], 1);
         chk({tag, "_wd1"}, wr_data_q[1], e1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_spikes = '0; cfg_beta = '0; cfg_v_th = '0;
      reset_on_spike = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out", out_spikes, 0);
      chk("rst_wrd", w_rd_en, 0);
      chk("rst_vrd", vmem_rd_en, 0);
      chk("rst_vwe", vmem_we, 0);
      chk("rst_beta", nrn_beta, 0);
      chk("rst_vth", nrn_v_th, 0);
      chk("rst_fsel", nrn_function_sel, 0);
      chk("rst_wgt", nrn_weight, 0);
      @(negedge clk); rst = 1'b0;

      // All inputs spike, weight 30: 4*30 = 120 >= 100
      load_rams(9'sd0, 9'sd0, 8'sd30);
      begin_ts(4'b1111, 8'd5, 8'd100);
      chk("t1_busy", busy, 1);
      chk("t1_vth_latched", nrn_v_th, 100);
      chk("t1_beta_latched", nrn_beta, 5);
      wait_done(0, lat);
      chk("t1_latency", lat, 15);
      chk("t1_done_busy", busy, 0);
      check_writes("t1", 9'sd120, 9'sd120);
      chk("t1_out", out_spikes, 2'b11);
      chk("t1_nrd", rd_addr_q.size(), 8);
      @(posedge clk); #1;
      chk("t1_done_pulse", done, 0);
      chk("t1_out_hold", out_spikes, 2'b11);

      // Sparse spikes: only k=0,2 read, 2*30 = 60 below threshold
      load_rams(9'sd0, 9'sd0, 8'sd30);
      begin_ts(4'b0101, 8'd5, 8'd100);
      wait_done(0, lat);
      chk("t2_latency", lat, 15);
      check_writes("t2", 9'sd60, 9'sd60);
      chk("t2_out", out_spikes, 2'b00);
      chk("t2_nrd", rd_addr_q.size(), 4);
      if (rd_addr_q.size() == 4) begin
         chk("t2_ra0", rd_addr_q[0], 0);
         chk("t2_ra1", rd_addr_q[1], 2);
         chk("t2_ra2", rd_addr_q[2], 4);
         chk("t2_ra3", rd_addr_q[3], 6);
      end

      // Positive overflow: 250 + 4*10
      reset_on_spike = 1'b1;
      load_rams(9'sd250, 9'sd0, 8'sd10);
      begin_ts(4'b1111, 8'd0, 8'd100);
      wait_done(0, lat);
      chk("t3_latency", lat, 15);
`ifdef SNN_SAT_EN
      check_writes("t3", 9'sd0, 9'sd40);
      chk("t3_out", out_spikes, 2'b01);
`else
      check_writes("t3", -9'sd222, 9'sd40);
      chk("t3_out", out_spikes, 2'b00);
`endif

      // Negative overflow: -200 + 2*(-100)
      load_rams(-9'sd200, -9'sd200, -8'sd100);
      begin_ts(4'b0011, 8'd0, 8'd100);
      wait_done(0, lat);
      chk("t4_latency", lat, 15);
`ifdef SNN_SAT_EN
      check_writes("t4", -9'sd256, -9'sd256);
      chk("t4_out", out_spikes, 2'b00);
`else
      check_writes("t4", 9'sd0, 9'sd0);
      chk("t4_out", out_spikes, 2'b11);
`endif

      // start pulsed while busy must be ignored
      reset_on_spike = 1'b0;
      load_rams(9'sd0, 9'sd0, 8'sd30);
      begin_ts(4'b1111, 8'd5, 8'd100);
      wait_done(5, lat);
      chk("t5_latency", lat, 15);
      check_writes("t5", 9'sd120, 9'sd120);
      @(posedge clk); #1;
      chk("t5_idle_busy", busy, 0);

      // Reset during ACC of neuron 1, then start on the first post-reset cycle
      load_rams(9'sd0, 9'sd0, 8'sd30);
      begin_ts(4'b1111, 8'd5, 8'd100);
      repeat (9) @(posedge clk);
      #1;
      chk("t6_pre_out", out_spikes, 2'b01);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_out", out_spikes, 0);
      chk("t6_rst_vwe", vmem_we, 0);
      chk("t6_rst_wrd", w_rd_en, 0);
      chk("t6_nwr", wr_data_q.size(), 1);
      chk("t6_vram1", vram[1], 0);
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      rst = 1'b0; start = 1'b1; in_spikes = 4'b1111; cfg_beta = 8'd5; cfg_v_th = 8'd100;
      @(posedge clk); #1;
      start = 1'b0;
      chk("t6_accept_busy", busy, 1);
      wait_done(0, lat);
      chk("t6_latency", lat, 15);
      check_writes("t6", 9'sd240, 9'sd120);
      chk("t6_out", out_spikes, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
